uart_tx_serializer: RTL and testbench

//  - Downstream consumer of the UART device's TX FIFO (ufifo).
//  - Pops queued bytes and serialises each one onto the TX line as 8N1 (optional parity) at a programmable baud rate.
//  - Runs entirely in the i_clk domain: the bit period comes from an internal divider counter, not a derived clock.
//  - Sits between the TX FIFO outputs (o_empty_n/o_data/i_rd) and the o_uart_tx pin.

---
 rtl/uart_tx_serializer.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out LSB first as start/data/stop frames.
// Define UART_TX_PARITY_EN to add a per-frame optional parity bit (i_parity_en / i_parity_odd ports).
module uart_tx_serializer #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [DIV_W-1:0] i_baud_div,
   input  logic             i_fifo_empty_n,
   input  logic [7:0]       i_fifo_data,
`ifdef UART_TX_PARITY_EN
   input  logic             i_parity_en,
   input  logic             i_parity_odd,
`endif
   output logic             o_fifo_rd,
   output logic             o_uart_tx,
   output logic             o_busy,
   output logic             o_frame_done
);

   localparam int BIT_W = 3;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 armed_q, armed_d;
   logic                 rd_q, rd_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pop;
`ifdef UART_TX_PARITY_EN
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
`endif

   // NOTE: state uses non-blocking assignments only; all next-state math lives in the always_comb below.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         armed_q   <= 1'b0;
         rd_q      <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         armed_q   <= armed_d;
         rd_q      <= rd_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   // NOTE: every variable gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      armed_d   = 1'b1;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif

      case (state_q)
         // armed_q blocks a pop on the first edge after reset release
         IDLE: pop = armed_q && i_fifo_empty_n;
         LOAD: begin
            state_d = START;
            cnt_d   = div_q;
         end
         START: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = div_q;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d   = div_q;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = par_en_q ? PARITY : STOP;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (cnt_q == '0) begin
               state_d = STOP;
               cnt_d   = div_q;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_q == '0) begin
               pop     = i_fifo_empty_n;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Divider and frame options are captured once per frame, at the pop.
      if (pop) begin
         state_d = LOAD;
         div_d   = i_baud_div;
         shift_d = i_fifo_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
         par_en_d  = i_parity_en;
         par_bit_d = (^i_fifo_data[DATA_BITS-1:0]) ^ i_parity_odd;
`endif
      end

      // Outputs are registered, so they are derived from the state being entered.
      rd_d   = pop;
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (cnt_d == '0);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_bit_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign o_fifo_rd    = rd_q;
   assign o_uart_tx    = tx_q;
   assign o_busy       = busy_q;
   assign o_frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (default build, no parity): frame-level cycle model
// plus a scoreboard that decodes each serial frame and compares it with the queued byte.
module tb_uart_tx_serializer;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [15:0] i_baud_div = '0;
   logic        i_fifo_empty_n = 1'b0;
   logic [7:0]  i_fifo_data = '0;
   logic        o_fifo_rd, o_uart_tx, o_busy, o_frame_done;

   uart_tx_serializer #(.DATA_BITS(8), .DIV_W(16)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_baud_div     (i_baud_div),
      .i_fifo_empty_n (i_fifo_empty_n),
      .i_fifo_data    (i_fifo_data),
      .o_fifo_rd      (o_fifo_rd),
      .o_uart_tx      (o_uart_tx),
      .o_busy         (o_busy),
      .o_frame_done   (o_frame_done)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- FIFO model and scoreboard queue ----------------
   typedef struct {
      logic [7:0] data;
      int         div;
   } frame_t;

   logic [7:0] fifo_q[$];
   frame_t     exp_q[$];
   int         cur_div = 0;
   logic       model_on = 1'b0;

   task automatic update_fifo();
      i_fifo_empty_n = (fifo_q.size() != 0);
      i_fifo_data    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic set_div(input int d);
      cur_div    = d;
      i_baud_div = 16'(d);
   endtask

   task automatic push_byte(input logic [7:0] b);
      frame_t f;
      f.data = b;
      f.div  = cur_div;
      fifo_q.push_back(b);
      exp_q.push_back(f);
      update_fifo();
   endtask

   // The FIFO pops on the strobe; the serializer never samples the FIFO during its LOAD cycle.
   initial forever begin
      @(negedge i_clk);
      if (model_on && !i_reset && o_fifo_rd === 1'b1) begin
         check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         update_fifo();
      end
   end

   // ---------------- Frame-level reference model ----------------
   // Phases: idle line, the single pop/LOAD cycle, and a flat frame of 10*(div+1) cycles.
   localparam int M_IDLE = 0, M_LOAD = 1, M_FRAME = 2;
   int         m_phase = M_IDLE;
   int         m_pos = 0;
   int         m_div = 0;
   logic [7:0] m_byte = '0;
   logic       m_armed = 1'b0;

   function automatic logic model_tx();
      int per, idx;
      if (m_phase != M_FRAME) return 1'b1;
      per = m_div + 1;
      idx = m_pos / per;
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return m_byte[idx-1];
   endfunction

   initial forever begin
      @(posedge i_clk or posedge i_reset);
      if (i_reset) begin
         m_phase = M_IDLE;
         m_pos   = 0;
         m_armed = 1'b0;
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (m_armed && i_fifo_empty_n) begin
                  m_phase = M_LOAD;
                  m_byte  = i_fifo_data;
                  m_div   = int'(i_baud_div);
               end
            end
            M_LOAD: begin
               m_phase = M_FRAME;
               m_pos   = 0;
            end
            default: begin
               if (m_pos == 10 * (m_div + 1) - 1) begin
                  if (i_fifo_empty_n) begin
                     m_phase = M_LOAD;
                     m_byte  = i_fifo_data;
                     m_div   = int'(i_baud_div);
                  end else begin
                     m_phase = M_IDLE;
                  end
               end else begin
                  m_pos++;
               end
            end
         endcase
         m_armed = 1'b1;
      end
   end

   // Per-cycle comparison of {o_fifo_rd, o_busy, o_uart_tx, o_frame_done}.
   initial forever begin
      logic [3:0] exp_vec;
      @(negedge i_clk);
      if (model_on) begin
         exp_vec = {m_phase == M_LOAD, m_phase != M_IDLE, model_tx(),
                    (m_phase == M_FRAME) && (m_pos == 10 * (m_div + 1) - 1)};
         check("cycle_rd_busy_tx_done", 32'({o_fifo_rd, o_busy, o_uart_tx, o_frame_done}), 32'(exp_vec));
      end
   end

   // ---------------- Scoreboard monitor: decode frames off the line ----------------
   logic   in_frame = 1'b0;
   logic   samples[$];
   frame_t cur;

   initial forever begin
      @(negedge i_clk);
      if (i_reset) begin
         in_frame = 1'b0;
         samples.delete();
      end else if (model_on && !in_frame) begin
         if (o_uart_tx === 1'b0) begin
            in_frame = 1'b1;
            samples.delete();
            samples.push_back(1'b0);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'(exp_q.size()), 32'd1);
               cur.data = 8'h00;
               cur.div  = 0;
            end else begin
               cur = exp_q.pop_front();
            end
         end
      end else if (in_frame) begin
         samples.push_back(o_uart_tx);
         if (o_frame_done === 1'b1) begin
            int len, per;
            logic [7:0] got;
            len = samples.size();
            per = len / 10;
            check("frame_len", 32'(len), 32'(10 * (cur.div + 1)));
            got = '0;
            for (int i = 0; i < 8; i++)
               if ((i + 1) * per + per / 2 < len) got[i] = samples[(i + 1) * per + per / 2];
            check("frame_byte", 32'(got), 32'(cur.data));
            check("stop_bit", 32'(samples[len-1]), 32'd1);
            in_frame = 1'b0;
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   // sel: 0 = line low, 1 = frame_done, 2 = fifo pop strobe
   task automatic wait_for(input int sel, input int budget, input string name);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge i_clk);
         case (sel)
            0:       hit = (o_uart_tx === 1'b0);
            1:       hit = (o_frame_done === 1'b1);
            default: hit = (o_fifo_rd === 1'b1);
         endcase
      end
      check(name, 32'(hit), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge i_clk);
         hit = (o_busy === 1'b0) && (fifo_q.size() == 0) && !in_frame;
      end
      check("wait_idle", 32'(hit), 32'd1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- Test sequence ----------------
   initial begin
      int n, rd_cnt;
      #1 i_reset = 1'b1;
      repeat (3) @(negedge i_clk);
      check("reset_tx", 32'(o_uart_tx), 32'd1);
      check("reset_rd", 32'(o_fifo_rd), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_done", 32'(o_frame_done), 32'd0);
      model_on = 1'b1;
      i_reset  = 1'b0;
      repeat (2) @(negedge i_clk);

      // Single byte at div=3: frame_done on the 40th cycle counted from the start bit.
      set_div(3);
      push_byte(8'hA5);
      wait_for(0, 20, "single_start_seen");
      n = 1;
      while (o_frame_done !== 1'b1 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      check("single_done_cycle", 32'(n), 32'd40);
      wait_idle(200);

      // Back-to-back at div=0: one LOAD cycle, line high, between frames.
      set_div(0);
      push_byte(8'h00);
      push_byte(8'hFF);
      wait_for(1, 50, "b2b_first_done");
      @(negedge i_clk);
      check("b2b_load_rd", 32'(o_fifo_rd), 32'd1);
      check("b2b_load_line", 32'(o_uart_tx), 32'd1);
      check("b2b_load_busy", 32'(o_busy), 32'd1);
      @(negedge i_clk);
      check("b2b_second_start", 32'(o_uart_tx), 32'd0);
      wait_idle(100);

      // Divider change mid-frame: current frame keeps 4-clock bits, next one uses 8.
      set_div(3);
      push_byte(8'h55);
      wait_for(2, 20, "divchg_pop");
      repeat (10) @(negedge i_clk);
      set_div(7);
      push_byte(8'(($urandom)));
      wait_idle(400);

      // Reset during data bit 3 aborts the frame without a clock edge.
      set_div(3);
      push_byte(8'(($urandom)));
      wait_for(2, 20, "rst_pop");
      repeat (18) @(negedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      check("rst_async_tx", 32'(o_uart_tx), 32'd1);
      check("rst_async_busy", 32'(o_busy), 32'd0);
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      rd_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_fifo_rd === 1'b1 || o_uart_tx !== 1'b1) rd_cnt++;
      end
      check("rst_release_quiet", 32'(rd_cnt), 32'd0);

      // Empty FIFO for 100 clocks, then a byte: start bit two clocks after it appears.
      rd_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_fifo_rd === 1'b1 || o_uart_tx !== 1'b1) rd_cnt++;
      end
      check("empty_quiet", 32'(rd_cnt), 32'd0);
      set_div(1);
      push_byte(8'h3C);
      n = 0;
      while (o_uart_tx !== 1'b0 && n < 10) begin
         @(negedge i_clk);
         n++;
      end
      check("empty_start_latency", 32'(n), 32'd2);
      wait_idle(100);

      // Randomized bursts: divider fixed per burst, bytes pushed with random gaps.
      for (int b = 0; b < 25; b++) begin
         set_div(int'($urandom_range(0, 4)));
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            push_byte(8'($urandom));
            repeat ($urandom_range(0, 15)) @(negedge i_clk);
         end
         wait_idle(600);
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
